audio_output_pacer: RTL and testbench

- Sits directly downstream of the audio sample FIFO.
- Pulls interleaved L/R signed 16-bit samples at a fixed output sample rate, derived from clk by a fractional accumulator.
- Presents a stable stereo pair to the DAC/mixer interface.
- Handles FIFO underrun by holding outputs, supports mono sources, and counts underruns for debug.

---
 rtl/audio_output_pacer.sv | 147 ++++++++++++++
 tb/tb_audio_output_pacer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_output_pacer.sv
// audio_output_pacer
// Pulls interleaved L/R signed 16-bit samples from the audio sample FIFO at a
// fixed output rate derived from clk by a fractional accumulator, and presents
// a stable stereo pair to the DAC/mixer side. Underruns hold the outputs and
// are counted (saturating) for debug. Mono sources feed both channels.
//
// Optional build macro: AUDIO_PACER_DECAY_EN
//   defined   -> on each underrun tick the outputs decay towards zero by an
//                arithmetic shift right (a result of -1 snaps to 0).
//   undefined -> outputs hold their last value on underrun.

module audio_output_pacer #(
  parameter int CLK_HZ = 30000000,
  parameter int OUT_HZ = 44100,
  parameter int ACC_W  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_write_i,
  input  logic [15:0] in_sample_i,
  output logic        in_strobe_o,
  input  logic        mono_i,
  output logic [15:0] out_left_o,
  output logic [15:0] out_right_o,
  output logic        out_tick_o,
  output logic        underrun_o,
  output logic [15:0] underrun_count_o
);

  typedef enum logic [1:0] {
    FETCH_L = 2'd0,
    FETCH_R = 2'd1,
    READY   = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] OUT_INC = ACC_W'(OUT_HZ);
  localparam logic [ACC_W-1:0] CLK_LIM = ACC_W'(CLK_HZ);

`ifdef AUDIO_PACER_DECAY_EN
  // Halve a signed sample towards zero; -1 would never reach 0 by shifting,
  // so it is snapped to 0 to guarantee silence after 16 steps.
  function automatic logic [15:0] decay_f(input logic [15:0] v);
    logic [15:0] s;
    s = {v[15], v[15:1]};
    if (s == 16'hFFFF) begin
      decay_f = 16'h0000;
    end else begin
      decay_f = s;
    end
  endfunction
`endif

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_sum_s;
  logic [ACC_W-1:0] acc_d;
  logic             tick_s;
  state_t           state_q;
  logic             mono_q;
  logic [15:0]      stage_l_q;
  logic [15:0]      stage_r_q;
  logic [15:0]      out_left_q;
  logic [15:0]      out_right_q;
  logic             out_tick_q;
  logic             underrun_q;
  logic [15:0]      underrun_count_q;
  logic             fetching_s;

  // Fractional rate generator: tick whenever the accumulator wraps past CLK_HZ.
  assign acc_sum_s = acc_q + OUT_INC;
  assign tick_s    = (acc_sum_s >= CLK_LIM);
  assign acc_d     = tick_s ? (acc_sum_s - CLK_LIM) : acc_sum_s;

  // A sample is consumed exactly when this is high; never during reset.
  assign fetching_s  = (state_q == FETCH_L) || (state_q == FETCH_R);
  assign in_strobe_o = fetching_s && in_write_i && !reset;

  assign out_left_o       = out_left_q;
  assign out_right_o      = out_right_q;
  assign out_tick_o       = out_tick_q;
  assign underrun_o       = underrun_q;
  assign underrun_count_o = underrun_count_q;

  // Pacer state: accumulator, fetch FSM, staging pair, outputs and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q            <= '0;
      state_q          <= FETCH_L;
      mono_q           <= 1'b0;
      stage_l_q        <= 16'h0000;
      stage_r_q        <= 16'h0000;
      out_left_q       <= 16'h0000;
      out_right_q      <= 16'h0000;
      out_tick_q       <= 1'b0;
      underrun_q       <= 1'b0;
      underrun_count_q <= 16'h0000;
    end else begin
      acc_q      <= acc_d;
      out_tick_q <= tick_s;
      underrun_q <= 1'b0;

      case (state_q)
        FETCH_L: begin
          if (in_strobe_o) begin
            stage_l_q <= in_sample_i;
            if (mono_q) begin
              stage_r_q <= in_sample_i;
              state_q   <= READY;
            end else begin
              state_q   <= FETCH_R;
            end
          end
        end
        FETCH_R: begin
          if (in_strobe_o) begin
            stage_r_q <= in_sample_i;
            state_q   <= READY;
          end
        end
        READY: begin
          if (tick_s) begin
            out_left_q  <= stage_l_q;
            out_right_q <= stage_r_q;
            mono_q      <= mono_i;
            state_q     <= FETCH_L;
          end
        end
        default: begin
          state_q <= FETCH_L;
        end
      endcase

      // A tick with no complete pair staged: pulse, count, hold (or decay).
      // Staging and state are left alone so a pending L keeps its slot.
      if (tick_s && fetching_s) begin
        underrun_q <= 1'b1;
        if (underrun_count_q != 16'hFFFF) begin
          underrun_count_q <= underrun_count_q + 16'd1;
        end
`ifdef AUDIO_PACER_DECAY_EN
        out_left_q  <= decay_f(out_left_q);
        out_right_q <= decay_f(out_right_q);
`endif
      end
    end
  end

endmodule

// File: tb/tb_audio_output_pacer.sv
// Directed, table-driven bench for audio_output_pacer with CLK_HZ=8, OUT_HZ=1
// (one output tick every 8 clocks). A small array-backed FIFO feeds the DUT.

module tb_audio_output_pacer;

  localparam int CLK_HZ = 8;
  localparam int OUT_HZ = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_write;
  logic [15:0] in_sample;
  logic        in_strobe;
  logic        mono = 1'b0;
  logic [15:0] out_left;
  logic [15:0] out_right;
  logic        out_tick;
  logic        underrun;
  logic [15:0] underrun_count;

  int checks = 0;
  int failures = 0;

  logic [15:0] fifo_mem [0:63];
  int wr_cnt = 0;
  int rd_idx = 0;
  int strobe_cnt = 0;

  audio_output_pacer #(
    .CLK_HZ(CLK_HZ),
    .OUT_HZ(OUT_HZ),
    .ACC_W (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_write_i      (in_write),
    .in_sample_i     (in_sample),
    .in_strobe_o     (in_strobe),
    .mono_i          (mono),
    .out_left_o      (out_left),
    .out_right_o     (out_right),
    .out_tick_o      (out_tick),
    .underrun_o      (underrun),
    .underrun_count_o(underrun_count)
  );

  always #5 clk = ~clk;

  assign in_write  = (rd_idx < wr_cnt);
  assign in_sample = fifo_mem[rd_idx[5:0]];

  // FIFO read side: pop on each strobe the DUT issues.
  always @(posedge clk) begin
    if (in_strobe) begin
      rd_idx     <= rd_idx + 1;
      strobe_cnt <= strobe_cnt + 1;
    end
  end

  typedef struct {
    logic        mono;
    int          npush;
    logic [15:0] s0, s1, s2, s3;
    logic [15:0] exp_l, exp_r;
    logic        exp_uf;
    logic [15:0] exp_cnt;
    int          exp_strobes;
  } vec_t;

  function automatic vec_t mk(input logic m, input int n,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d,
                              input logic [15:0] el, input logic [15:0] er,
                              input logic uf, input logic [15:0] cnt,
                              input int strb);
    vec_t v;
    v.mono = m; v.npush = n;
    v.s0 = a; v.s1 = b; v.s2 = c; v.s3 = d;
    v.exp_l = el; v.exp_r = er; v.exp_uf = uf; v.exp_cnt = cnt;
    v.exp_strobes = strb;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    fifo_mem[wr_cnt[5:0]] = v;
    wr_cnt++;
  endtask

  // Waits (bounded) for the next out_tick; outputs must stay put until then.
  task automatic wait_tick(output int cycles);
    logic [15:0] hold_l;
    logic [15:0] hold_r;
    hold_l = out_left;
    hold_r = out_right;
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (!out_tick) begin
        check("held_left", out_left, hold_l);
        check("held_right", out_right, hold_r);
        check("no_uf_between_ticks", {15'd0, underrun}, 16'd0);
      end
    end while (!out_tick && cycles < 20);
    if (!out_tick) begin
      check("tick_timeout", {15'd0, out_tick}, 16'd1);
    end
  endtask

  vec_t vecs [9];
  logic [15:0] u_l [3];
  logic [15:0] u_r [3];
  logic [15:0] fin_l, fin_r;

  initial begin
    int cyc;
    int s_start;
    int rd_snap;

    for (int i = 0; i < 64; i++) fifo_mem[i] = 16'h0000;

`ifdef AUDIO_PACER_DECAY_EN
    u_l[0] = 16'hC000; u_r[0] = 16'hC000;
    u_l[1] = 16'hE000; u_r[1] = 16'hE000;
    u_l[2] = 16'h2000; u_r[2] = 16'hE000;
    fin_l = 16'h0000;  fin_r = 16'h0000;
`else
    u_l[0] = 16'h8000; u_r[0] = 16'h8000;
    u_l[1] = 16'h8000; u_r[1] = 16'h8000;
    u_l[2] = 16'h4000; u_r[2] = 16'hC000;
    fin_l = 16'h4000;  fin_r = 16'hC000;
`endif

    //           mono n  s0        s1        s2        s3        expL      expR      uf    cnt     strobes
    vecs[0] = mk(1'b0, 4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111, 16'h2222, 1'b0, 16'd5, 2);
    vecs[1] = mk(1'b1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3333, 16'h4444, 1'b0, 16'd5, 2);
    vecs[2] = mk(1'b1, 2, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b0, 16'd5, 1);
    vecs[3] = mk(1'b0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 1'b0, 16'd5, 1);
    vecs[4] = mk(1'b0, 1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, u_l[0],   u_r[0],   1'b1, 16'd6, 1);
    vecs[5] = mk(1'b0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, u_l[1],   u_r[1],   1'b1, 16'd7, 0);
    vecs[6] = mk(1'b0, 1, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0200, 1'b0, 16'd7, 1);
    vecs[7] = mk(1'b0, 2, 16'h4000, 16'hC000, 16'h0000, 16'h0000, 16'h4000, 16'hC000, 1'b0, 16'd7, 2);
    vecs[8] = mk(1'b0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, u_l[2],   u_r[2],   1'b1, 16'd8, 0);

    // Reset state.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_left", out_left, 16'h0000);
    check("rst_right", out_right, 16'h0000);
    check("rst_tick", {15'd0, out_tick}, 16'd0);
    check("rst_uf", {15'd0, underrun}, 16'd0);
    check("rst_cnt", underrun_count, 16'd0);
    reset = 1'b0;

    // Tick rate with an empty FIFO: every tick is an underrun, 8 clocks apart.
    for (int t = 0; t < 5; t++) begin
      wait_tick(cyc);
      check("tick_period", 16'(cyc), 16'd8);
      check("idle_uf", {15'd0, underrun}, 16'd1);
      check("idle_cnt", underrun_count, 16'(t + 1));
      check("idle_left", out_left, 16'h0000);
    end

    // Table: stereo, mono, mid-pair mono change, partial pair, decay start.
    for (int i = 0; i < 9; i++) begin
      mono = vecs[i].mono;
      if (vecs[i].npush > 0) push(vecs[i].s0);
      if (vecs[i].npush > 1) push(vecs[i].s1);
      if (vecs[i].npush > 2) push(vecs[i].s2);
      if (vecs[i].npush > 3) push(vecs[i].s3);
      s_start = strobe_cnt;
      wait_tick(cyc);
      check($sformatf("v%0d_period", i), 16'(cyc), 16'd8);
      check($sformatf("v%0d_left", i), out_left, vecs[i].exp_l);
      check($sformatf("v%0d_right", i), out_right, vecs[i].exp_r);
      check($sformatf("v%0d_uf", i), {15'd0, underrun}, {15'd0, vecs[i].exp_uf});
      check($sformatf("v%0d_cnt", i), underrun_count, vecs[i].exp_cnt);
      check($sformatf("v%0d_strobes", i), 16'(strobe_cnt - s_start), 16'(vecs[i].exp_strobes));
    end

    // Prolonged starvation: 15 more underruns (16 in total since 0x4000/0xC000).
    for (int t = 0; t < 15; t++) begin
      wait_tick(cyc);
      check("starve_uf", {15'd0, underrun}, 16'd1);
    end
    check("starve_left", out_left, fin_l);
    check("starve_right", out_right, fin_r);
    check("starve_cnt", underrun_count, 16'd23);

    // Reset while in FETCH_R with L staged.
    push(16'h0AAA);
    @(posedge clk);
    #1;
    check("pre_rst_consumed", 16'(rd_idx), 16'(wr_cnt));
    push(16'h0BBB);
    reset = 1'b1;
    #1;
    check("rst_strobe_low", {15'd0, in_strobe}, 16'd0);
    rd_snap = rd_idx;
    repeat (2) @(posedge clk);
    #1;
    check("rst2_no_pop", 16'(rd_idx), 16'(rd_snap));
    check("rst2_left", out_left, 16'h0000);
    check("rst2_right", out_right, 16'h0000);
    check("rst2_cnt", underrun_count, 16'd0);
    check("rst2_tick", {15'd0, out_tick}, 16'd0);
    reset = 1'b0;
    push(16'h0CCC);
    wait_tick(cyc);
    check("post_rst_period", 16'(cyc), 16'd8);
    check("post_rst_left", out_left, 16'h0BBB);
    check("post_rst_right", out_right, 16'h0CCC);
    check("post_rst_uf", {15'd0, underrun}, 16'd0);
    check("post_rst_cnt", underrun_count, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
